// File: rtl/nibble_add_sequencer.sv
// rtl/nibble_add_sequencer.sv - WIDTH-bit add/sub sequenced one nibble per clock through an external 4-bit ripple adder.
// Optional zero-result flag port enabled by defining NIBBLE_SEQ_ZERO_FLAG_EN.
module nibble_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
`ifdef NIBBLE_SEQ_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_s,
    input  logic             add_cout
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        add_a       = 4'h0;
        add_b       = 4'h0;
        add_cin     = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    // Subtraction is folded into the operands: A + ~B + 1.
                    a_d        = a;
                    b_d        = sub ? ~b : b;
                    carry_d    = sub ? 1'b1 : cin;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                add_a   = a_q[4*idx_q +: 4];
                add_b   = b_q[4*idx_q +: 4];
                add_cin = carry_q;
                sum_d[4*idx_q +: 4] = add_s;
                carry_d = add_cout;
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d      = add_cout;
                    ovf_d       = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_s[3] != a_q[WIDTH-1]);
                    zero_d      = (sum_d == '0);
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    zero_d      = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
`ifdef NIBBLE_SEQ_ZERO_FLAG_EN
    assign zero      = zero_q;
`else
    logic unused_zero;
    assign unused_zero = zero_q;
`endif

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// tb/tb_nibble_add_sequencer.sv - scoreboard bench for nibble_add_sequencer with an arithmetic reference model.
module tb_nibble_add_sequencer;

    localparam int W   = 8;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout, ovf;
`ifdef NIBBLE_SEQ_ZERO_FLAG_EN
    logic         zero;
`endif
    logic [3:0]   add_a, add_b, add_s;
    logic         add_cin, add_cout;

    logic ready_fixed, rand_ready, rnd_ready;

    always #5 clk = ~clk;

    // Combinational 4-bit ripple adder sitting outside the sequencer.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
    assign out_ready = rand_ready ? rnd_ready : ready_fixed;

    always @(posedge clk) begin
        #1;
        rnd_ready = 1'($urandom);
    end

    nibble_add_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf),
`ifdef NIBBLE_SEQ_ZERO_FLAG_EN
        .zero(zero),
`endif
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout)
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       si;
        logic [7:0] s;
        logic       c;
        logic       v;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[0:9];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                   input logic ci, input logic si);
        exp_t        m;
        int unsigned ua = ai;
        int unsigned ub = bi;
        int unsigned mask = (32'd1 << W) - 1;
        int unsigned ru;
        int sa = $signed(ai);
        int sb = $signed(bi);
        int rs;
        if (si) begin
            ru = ua + ((~ub) & mask) + 1;
            rs = sa - sb;
        end else begin
            ru = ua + ub + 32'(ci);
            rs = sa + sb + int'(ci);
        end
        m.s = ru[W-1:0];
        m.c = ru[W];
        m.v = (rs > (2 ** (W - 1)) - 1) || (rs < -(2 ** (W - 1)));
        m.z = (m.s == '0);
        return m;
    endfunction

    function automatic exp_t from_vec(input vec_t v);
        exp_t e;
        e.s = v.s;
        e.c = v.c;
        e.v = v.v;
        e.z = (v.s == 8'h00);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got sum=%0h expected no result", sum);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sum", 32'(sum), 32'(e.s));
                chk("cout", 32'(cout), 32'(e.c));
                chk("ovf", 32'(ovf), 32'(e.v));
`ifdef NIBBLE_SEQ_ZERO_FLAG_EN
                chk("zero", 32'(zero), 32'(e.z));
`endif
            end
        end
    end

    task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                         input logic si, input exp_t e, output bit ok);
        in_valid = 1'b1;
        a = ai; b = bi; cin = ci; sub = si;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(e);
                ok = 1'b1;
            end
        end
        if (!ok) fail_now("accept");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    endtask

    task automatic directed(input vec_t v);
        bit ok;
        int unsigned ua = v.a;
        int unsigned ubp = v.si ? ((~32'(v.b)) & 32'hFF) : 32'(v.b);
        int unsigned c0 = v.si ? 1 : 32'(v.ci);
        issue(v.a, v.b, v.ci, v.si, from_vec(v), ok);
        if (!ok) return;
        for (int i = 0; i < NIB; i++) begin
            int unsigned low = (32'd1 << (4 * i)) - 1;
            @(negedge clk);
            chk("add_a", 32'(add_a), (ua >> (4 * i)) & 32'hF);
            chk("add_b", 32'(add_b), (ubp >> (4 * i)) & 32'hF);
            chk("add_cin", 32'(add_cin), (((ua & low) + (ubp & low) + c0) >> (4 * i)) & 1);
            chk("run_out_valid", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit   ok;
        exp_t e;
        int   n;
        vecs[0] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h5A, 8'h25, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[6] = '{8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[7] = '{8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[8] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[9] = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        ready_fixed = 1'b1; rand_ready = 1'b0; rnd_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
        chk("rst_adder_if", 32'({add_a, add_b, add_cin}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("release_in_ready_before_edge", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) directed(vecs[i]);

        // Backpressure: result held while a competing request waits.
        ready_fixed = 1'b0;
        e = model(8'hA5, 8'h3C, 1'b1, 1'b0);
        issue(8'hA5, 8'h3C, 1'b1, 1'b0, e, ok);
        in_valid = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0;
        for (n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        if (!out_valid) fail_now("stall_out_valid");
        repeat (5) begin
            @(negedge clk);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_sum", 32'(sum), 32'(e.s));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ready_fixed = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_idle_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Reset during the second RUN cycle discards the partial result.
        e = model(8'h77, 8'h22, 1'b0, 1'b0);
        issue(8'h77, 8'h22, 1'b0, 1'b0, e, ok);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_adder_if", 32'({add_a, add_b, add_cin}), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        if (sb_q.size() != 0) void'(sb_q.pop_back());
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        directed(vecs[9]);

        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            logic [W-1:0] ra, rb;
            logic         rc, rs;
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            issue(ra, rb, rc, rs, model(ra, rb, rc, rs), ok);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        for (n = 0; n < 300 && sb_q.size() != 0; n++) @(negedge clk);
        if (sb_q.size() != 0) fail_now("drain");
        rand_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
